// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller takes the master side; the datapath takes the slave side.
interface mips_multicycle_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] PCSrc;
    logic [2:0] AluCtl;
    logic       ExtOp;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
               RegWrite, AluSrcA, AluSrcB, PCSrc, AluCtl, ExtOp, Illegal, State
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
               RegWrite, AluSrcA, AluSrcB, PCSrc, AluCtl, ExtOp, Illegal, State
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for one instruction at a time and drives every datapath select and enable.
module mips_multicycle_ctrl (
    input  logic                   CLK,
    input  logic                   Reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t     stateReg;
    state_t     stateNext;
    state_t     stateLoad;
    logic       illegalNext;
    logic       functLegal;
    logic [2:0] functAluCtl;
    logic [2:0] immAluCtl;
    logic       immExtOp;

    logic       iorDReg;
    logic       memReadReg;
    logic       memWriteReg;
    logic       memToRegReg;
    logic       regDstReg;
    logic       regWriteReg;
    logic       aluSrcAReg;
    logic [1:0] aluSrcBReg;
    logic [1:0] pcSrcReg;
    logic [2:0] aluCtlReg;
    logic       extOpReg;
    logic       pcWriteReg;
    logic       branchReg;

    always_comb begin
        functLegal  = 1'b1;
        functAluCtl = ALU_ADD;
        case (bus.Funct)
            F_ADD:   functAluCtl = ALU_ADD;
            F_SUB:   functAluCtl = ALU_SUB;
            F_AND:   functAluCtl = ALU_AND;
            F_OR:    functAluCtl = ALU_OR;
            F_SLT:   functAluCtl = ALU_SLT;
            default: functLegal  = 1'b0;
        endcase
    end

    always_comb begin
        immAluCtl = ALU_ADD;
        immExtOp  = 1'b1;
        case (bus.Op)
            OP_ANDI: begin immAluCtl = ALU_AND; immExtOp = 1'b0; end
            OP_ORI:  begin immAluCtl = ALU_OR;  immExtOp = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        stateNext   = FETCH;
        illegalNext = 1'b0;
        case (stateReg)
            FETCH:   stateNext = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW:              stateNext = MEMADR;
                    OP_RTYPE:                  stateNext = EXECUTE;
                    OP_BEQ:                    stateNext = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  stateNext = IMMEX;
                    OP_J:                      stateNext = JUMP;
                    default:                   illegalNext = 1'b1;
                endcase
            end
            MEMADR:  stateNext = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   stateNext = bus.MemReady ? MEMWB : MEMRD;
            MEMWR:   stateNext = bus.MemReady ? FETCH : MEMWR;
            EXECUTE: begin
                if (functLegal) stateNext = ALUWB;
                else            illegalNext = 1'b1;
            end
            IMMEX:   stateNext = IMMWB;
            default: stateNext = FETCH;
        endcase
    end

    assign stateLoad = Reset ? FETCH : stateNext;

    // Moore outputs are decoded from the state being entered so they are
    // valid straight out of flops for the whole cycle spent in that state.
    always_ff @(posedge CLK) begin
        if (Reset) stateReg <= FETCH;
        else       stateReg <= stateNext;

        iorDReg     <= 1'b0;
        memReadReg  <= 1'b0;
        memWriteReg <= 1'b0;
        memToRegReg <= 1'b0;
        regDstReg   <= 1'b0;
        regWriteReg <= 1'b0;
        aluSrcAReg  <= 1'b0;
        aluSrcBReg  <= 2'b00;
        pcSrcReg    <= 2'b00;
        aluCtlReg   <= ALU_ADD;
        extOpReg    <= 1'b1;
        pcWriteReg  <= 1'b0;
        branchReg   <= 1'b0;
        case (stateLoad)
            FETCH:   begin memReadReg <= 1'b1; aluSrcBReg <= 2'b01; end
            DECODE:  aluSrcBReg <= 2'b11;
            MEMADR:  begin aluSrcAReg <= 1'b1; aluSrcBReg <= 2'b10; end
            MEMRD:   begin iorDReg <= 1'b1; memReadReg <= 1'b1; end
            MEMWB:   begin memToRegReg <= 1'b1; regWriteReg <= 1'b1; end
            MEMWR:   begin iorDReg <= 1'b1; memWriteReg <= 1'b1; end
            EXECUTE: begin aluSrcAReg <= 1'b1; aluCtlReg <= functAluCtl; end
            ALUWB:   begin regDstReg <= 1'b1; regWriteReg <= 1'b1; end
            BRANCH: begin
                aluSrcAReg <= 1'b1;
                aluCtlReg  <= ALU_SUB;
                pcSrcReg   <= 2'b01;
                branchReg  <= 1'b1;
            end
            IMMEX: begin
                aluSrcAReg <= 1'b1;
                aluSrcBReg <= 2'b10;
                aluCtlReg  <= immAluCtl;
                extOpReg   <= immExtOp;
            end
            IMMWB:   regWriteReg <= 1'b1;
            JUMP:    begin pcSrcReg <= 2'b10; pcWriteReg <= 1'b1; end
            default: ;
        endcase
    end

    // Reset must silence every side effect immediately, whatever state we are in.
    assign bus.IRWrite  = ~Reset & (stateReg == FETCH) & bus.MemReady;
    assign bus.PCEn     = ~Reset & (((stateReg == FETCH) & bus.MemReady) |
                                    pcWriteReg | (branchReg & bus.Zero));
    assign bus.MemRead  = ~Reset & memReadReg;
    assign bus.MemWrite = ~Reset & memWriteReg;
    assign bus.RegWrite = ~Reset & regWriteReg;
    assign bus.Illegal  = ~Reset & illegalNext;
    assign bus.IorD     = iorDReg;
    assign bus.MemToReg = memToRegReg;
    assign bus.RegDst   = regDstReg;
    assign bus.AluSrcA  = aluSrcAReg;
    assign bus.AluSrcB  = aluSrcBReg;
    assign bus.PCSrc    = pcSrcReg;
    assign bus.AluCtl   = aluCtlReg;
    assign bus.ExtOp    = extOpReg;
    assign bus.State    = stateReg;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed and random instructions
// compared cycle by cycle against a per-instruction phase model.
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic       pcEn, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA;
        logic [1:0] aluSrcB, pcSrc;
        logic [2:0] aluCtl;
        logic       extOp, illegal;
    } outs_t;

    typedef struct {
        logic  memReady;
        logic  zero;
        outs_t o;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    int   nCompared = 0;
    int   nMismatched = 0;
    cyc_t expQ[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl dut (
        .CLK   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t base(input logic [3:0] s);
        outs_t o;
        o        = '0;
        o.st     = s;
        o.aluCtl = 3'b010;
        o.extOp  = 1'b1;
        return o;
    endfunction

    function automatic outs_t observed();
        outs_t g;
        g.st = bus.State;       g.pcEn = bus.PCEn;         g.iorD = bus.IorD;
        g.memRead = bus.MemRead; g.memWrite = bus.MemWrite; g.irWrite = bus.IRWrite;
        g.memToReg = bus.MemToReg; g.regDst = bus.RegDst;  g.regWrite = bus.RegWrite;
        g.aluSrcA = bus.AluSrcA; g.aluSrcB = bus.AluSrcB;  g.pcSrc = bus.PCSrc;
        g.aluCtl = bus.AluCtl;  g.extOp = bus.ExtOp;       g.illegal = bus.Illegal;
        return g;
    endfunction

    task automatic push(input logic mr, input logic z, input outs_t o);
        cyc_t c;
        c.memReady = mr;
        c.zero     = z;
        c.o        = o;
        expQ.push_back(c);
    endtask

    // Reference: expand one instruction into its phase list (state, outputs, inputs to drive).
    task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                         input int fw, input int mw);
        outs_t o;
        logic  rdy;
        logic  legal;
        for (int i = 0; i <= fw; i++) begin
            rdy = (i == fw);
            o = base(0); o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = rdy; o.pcEn = rdy;
            push(rdy, rnd(), o);
        end
        o = base(1); o.aluSrcB = 2'b11;
        case (op)
            OP_LW, OP_SW: begin
                push(rnd(), rnd(), o);
                o = base(2); o.aluSrcA = 1; o.aluSrcB = 2'b10;
                push(rnd(), rnd(), o);
                for (int i = 0; i <= mw; i++) begin
                    rdy = (i == mw);
                    if (op == OP_LW) begin o = base(3); o.iorD = 1; o.memRead = 1; end
                    else             begin o = base(5); o.iorD = 1; o.memWrite = 1; end
                    push(rdy, rnd(), o);
                end
                if (op == OP_LW) begin
                    o = base(4); o.memToReg = 1; o.regWrite = 1;
                    push(rnd(), rnd(), o);
                end
            end
            OP_R: begin
                push(rnd(), rnd(), o);
                o = base(6); o.aluSrcA = 1; legal = 1'b1;
                case (funct)
                    6'b100000: o.aluCtl = 3'b010;
                    6'b100010: o.aluCtl = 3'b110;
                    6'b100100: o.aluCtl = 3'b000;
                    6'b100101: o.aluCtl = 3'b001;
                    6'b101010: o.aluCtl = 3'b111;
                    default:   legal = 1'b0;
                endcase
                o.illegal = ~legal;
                push(rnd(), rnd(), o);
                if (legal) begin
                    o = base(7); o.regDst = 1; o.regWrite = 1;
                    push(rnd(), rnd(), o);
                end
            end
            OP_BEQ: begin
                push(rnd(), rnd(), o);
                o = base(8); o.aluSrcA = 1; o.aluCtl = 3'b110; o.pcSrc = 2'b01; o.pcEn = zero;
                push(rnd(), zero, o);
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                push(rnd(), rnd(), o);
                o = base(9); o.aluSrcA = 1; o.aluSrcB = 2'b10;
                if (op == OP_ANDI)     begin o.aluCtl = 3'b000; o.extOp = 0; end
                else if (op == OP_ORI) begin o.aluCtl = 3'b001; o.extOp = 0; end
                push(rnd(), rnd(), o);
                o = base(10); o.regWrite = 1;
                push(rnd(), rnd(), o);
            end
            OP_J: begin
                push(rnd(), rnd(), o);
                o = base(11); o.pcSrc = 2'b10; o.pcEn = 1;
                push(rnd(), rnd(), o);
            end
            default: begin
                o.illegal = 1;
                push(rnd(), rnd(), o);
            end
        endcase
    endtask

    // Starts at posedge+1 with the DUT in FETCH; ends at posedge+1 back in FETCH.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input int fw, input int mw);
        outs_t got;
        expQ.delete();
        build(op, funct, zero, fw, mw);
        bus.Op    = op;
        bus.Funct = funct;
        foreach (expQ[i]) begin
            bus.MemReady = expQ[i].memReady;
            bus.Zero     = expQ[i].zero;
            @(negedge clk);
            got = observed();
            nCompared++;
            if (got !== expQ[i].o) begin
                nMismatched++;
                $display("FAIL %s cycle %0d: outputs got %h required %h", name, i, got, expQ[i].o);
            end
            @(posedge clk); #1;
        end
        $display("instr %-10s op=%b funct=%b zero=%b fetchWait=%0d memWait=%0d cycles=%0d",
                 name, op, funct, zero, fw, mw, expQ.size());
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.MemReady = 1'b1; bus.Op = OP_SW; bus.Funct = '0; bus.Zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++;
        if ({bus.State, bus.MemRead, bus.IRWrite, bus.PCEn, bus.RegWrite, bus.MemWrite} !== 9'h000) begin
            nMismatched++;
            $display("FAIL reset_hold: state/enables got %h required 000",
                     {bus.State, bus.MemRead, bus.IRWrite, bus.PCEn, bus.RegWrite, bus.MemWrite});
        end
        @(posedge clk); #1;
        reset = 1'b0; bus.MemReady = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({bus.State, bus.MemRead, bus.IRWrite} !== 6'b0000_10) begin
            nMismatched++;
            $display("FAIL reset_release: state/MemRead/IRWrite got %b required 000010",
                     {bus.State, bus.MemRead, bus.IRWrite});
        end
        @(posedge clk); #1;
        $display("test reset done");
    endtask

    task automatic test_reset_in_memwr();
        bus.Op = OP_SW; bus.MemReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.MemReady = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++;
        if ({bus.State, bus.MemWrite} !== 5'b0101_1) begin
            nMismatched++;
            $display("FAIL memwr_entry: state/MemWrite got %b required 01011", {bus.State, bus.MemWrite});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        nCompared++;
        if ({bus.State, bus.MemWrite, bus.MemRead, bus.RegWrite} !== 7'b0101_000) begin
            nMismatched++;
            $display("FAIL memwr_reset1: state/MemWrite/MemRead/RegWrite got %b required 0101000",
                     {bus.State, bus.MemWrite, bus.MemRead, bus.RegWrite});
        end
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++;
        if ({bus.State, bus.MemWrite, bus.MemRead} !== 6'b0000_00) begin
            nMismatched++;
            $display("FAIL memwr_reset2: state/MemWrite/MemRead got %b required 000000",
                     {bus.State, bus.MemWrite, bus.MemRead});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({bus.State, bus.MemRead} !== 5'b0000_1) begin
            nMismatched++;
            $display("FAIL memwr_after: state/MemRead got %b required 00001", {bus.State, bus.MemRead});
        end
        @(posedge clk); #1;
        $display("test reset_in_memwr done");
    endtask

    task automatic test_load_store();
        run_instr("lw", OP_LW, 6'($urandom), 1'b0, 0, 0);
        run_instr("sw", OP_SW, 6'($urandom), 1'b1, 0, 0);
        run_instr("lw_wait", OP_LW, 6'($urandom), 1'b0, 0, 2);
        run_instr("sw_wait", OP_SW, 6'($urandom), 1'b0, 1, 3);
    endtask

    task automatic test_rtype();
        run_instr("slt", OP_R, 6'b101010, 1'b0, 0, 0);
        run_instr("add", OP_R, 6'b100000, 1'b1, 0, 0);
        run_instr("sub", OP_R, 6'b100010, 1'b0, 0, 0);
        run_instr("and", OP_R, 6'b100100, 1'b0, 0, 0);
        run_instr("or", OP_R, 6'b100101, 1'b0, 0, 0);
    endtask

    task automatic test_branch_jump();
        run_instr("beq_taken", OP_BEQ, 6'($urandom), 1'b1, 0, 0);
        run_instr("beq_not", OP_BEQ, 6'($urandom), 1'b0, 0, 0);
        run_instr("j", OP_J, 6'($urandom), 1'b0, 0, 0);
    endtask

    task automatic test_immediate();
        run_instr("ori", OP_ORI, 6'($urandom), 1'b0, 0, 0);
        run_instr("addi", OP_ADDI, 6'($urandom), 1'b0, 0, 0);
        run_instr("andi", OP_ANDI, 6'($urandom), 1'b1, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("bad_op", 6'b111111, 6'b100000, 1'b0, 0, 0);
        run_instr("bad_funct", OP_R, 6'b000111, 1'b0, 0, 0);
    endtask

    task automatic test_fetch_wait();
        run_instr("fetch_wait", OP_ADDI, 6'b0, 1'b0, 3, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J, 6'b0};
        logic [5:0] functs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b0};
        logic [5:0] op;
        logic [5:0] funct;
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 6'b0 && $urandom_range(0, 3) == 0) op = 6'($urandom);
            funct = functs[$urandom_range(0, 5)];
            if (funct == 6'b0) funct = 6'($urandom);
            run_instr("random", op, funct, rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_reset_in_memwr();
        test_load_store();
        test_rtype();
        test_branch_jump();
        test_immediate();
        test_illegal();
        test_fetch_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
